// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the operation is accepted and parked in pending
// registers. A down-counter then holds busy for the configured latency, and
// HI/LO are updated in a single commit when the count runs out.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | ready; start with MULT*/DIV* launches, MTHI/MTLO write directly
//   S_RUN  | operation in flight; counter runs down, start is ignored
module mul_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   div_b, quo_s, rem_s, quo_u, rem_u;
  logic               div_zero, div_ovf;

  // Arithmetic datapath: all four results are formed from the current operands
  always_comb begin
    prod_s   = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    prod_u   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    div_zero = (B == '0);
    div_ovf  = (A == MOST_NEG) && (B == ALL_ONES);
    // A dummy divisor keeps the dividers well defined; the zero case is muxed out below
    div_b    = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
    quo_s    = $signed(A) / $signed(div_b);
    rem_s    = $signed(A) % $signed(div_b);
    quo_u    = A / div_b;
    rem_u    = A % div_b;
    if (div_ovf) begin
      quo_s = A;
      rem_s = '0;
    end
  end

  // Next-state and register-update logic for the IDLE/RUN controller
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d   = S_RUN;
              busy_d    = 1'b1;
              cnt_d     = CW'(MUL_LAT);
              pend_hi_d = (op == OP_MULT) ? prod_s[2*WIDTH-1:WIDTH] : prod_u[2*WIDTH-1:WIDTH];
              pend_lo_d = (op == OP_MULT) ? prod_s[WIDTH-1:0]       : prod_u[WIDTH-1:0];
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_RUN;
              busy_d  = 1'b1;
              cnt_d   = CW'(DIV_LAT);
              if (div_zero) begin
                pend_hi_d = A;
                pend_lo_d = ALL_ONES;
              end else begin
                pend_hi_d = (op == OP_DIV) ? rem_s : rem_u;
                pend_lo_d = (op == OP_DIV) ? quo_s : quo_u;
              end
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        // Commit on the edge where the counter reaches zero
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, pending and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic reference.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic [W-1:0] HI, LO;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mul_div_unit #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: results follow directly from the arithmetic definition of each op
  function automatic void ref_exec(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   inout logic [W-1:0] hi, inout logic [W-1:0] lo, output int lat);
    longint       ps;
    logic [63:0]  pu;
    int           sa, sb;
    lat = 0;
    sa = a;
    sb = b;
    case (o)
      3'd1: begin
        ps = longint'(sa) * longint'(sb);
        pu = ps;
        hi = pu[63:32]; lo = pu[31:0]; lat = 5;
      end
      3'd2: begin
        pu = {32'd0, a} * {32'd0, b};
        hi = pu[63:32]; lo = pu[31:0]; lat = 5;
      end
      3'd3: begin
        lat = 10;
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 0; lo = a; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      3'd4: begin
        lat = 10;
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op from idle, scramble the inputs afterwards, then track busy and the commit
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] ehi, elo, ohi, olo;
    int lat, cyc;
    ohi = m_hi; olo = m_lo; ehi = m_hi; elo = m_lo;
    ref_exec(o, a, b, ehi, elo, lat);
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      chk({tag, "_hi_hold"}, HI, ohi);
      chk({tag, "_lo_hold"}, LO, olo);
      cyc++;
      step();
    end
    chk({tag, "_busy_cycles"}, cyc, lat);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    int cyc;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    reset = 1'b1;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_hi", HI, 0);
    chk("reset_lo", LO, 0);
    step();
    reset = 1'b0;
    step();

    do_op(3'd5, 32'h1234_5678, 32'h0, "mthi");
    do_op(3'd6, 32'hCAFE_0001, 32'h0, "mtlo");
    do_op(3'd0, 32'hDEAD_BEEF, 32'h1, "nop");
    do_op(3'd7, 32'hDEAD_BEEF, 32'h1, "op111");
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult");
    do_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(3'd4, 32'd7, 32'd2, "divu");
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd4, 32'h55, 32'h0, "divu_zero");
    do_op(3'd3, 32'h8000_0001, 32'h0, "div_zero");
    do_op(3'd3, 32'd7, 32'hFFFF_FFFE, "div_pos_neg");

    // start while busy: MTLO and DIV during a MULT must both be dropped
    reset = 1'b1; #1; reset = 1'b0; m_hi = 0; m_lo = 0;
    step();
    start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
    step();
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin start = 1'b1; op = 3'd6; A = 32'hAA; B = 32'd0; end
      if (cyc == 3) begin start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7; end
      if (cyc == 4) start = 1'b0;
      step();
    end
    chk("busy_ign_cycles", cyc, 5);
    chk("busy_ign_hi", HI, 0);
    chk("busy_ign_lo", LO, 12);
    step();
    chk("busy_ign_late_busy", busy, 0);
    chk("busy_ign_late_lo", LO, 12);
    m_hi = 0; m_lo = 12;

    // reset mid-operation discards the pending result
    do_op(3'd5, 32'h1111_1111, 32'h0, "pre_rst_hi");
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("midop_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_hi", HI, 0);
    chk("midop_rst_lo", LO, 0);
    #1;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    for (int i = 0; i < 12; i++) step();
    chk("midop_no_commit_busy", busy, 0);
    chk("midop_no_commit_hi", HI, 0);
    chk("midop_no_commit_lo", LO, 0);
    do_op(3'd1, 32'd2, 32'd2, "post_rst_mult");

    // random ops, issued back-to-back with no idle cycle between them
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 0;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      do_op(ro, ra, rb, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, sitting in the EX stage beside the combinational ALU. It accepts one operation per start pulse and holds `busy` for a fixed, parameter-set latency. It then commits the full-width product, or the quotient and remainder, into HI/LO. The stall controller uses `busy` and `start` to freeze any later instruction that touches HI/LO or needs the unit.

## Interface
- `WIDTH`, 32: operand and HI/LO register width.
- `MUL_LAT`, 5: cycles `busy` stays high for MULT/MULTU; must be ≥1.
- `DIV_LAT`, 10: cycles `busy` stays high for DIV/DIVU; must be ≥1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  sample `op`/`A`/`B` this cycle.
- `op`  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 is treated as NOP.
- `A`  in  WIDTH  operand 1 (dividend, or the MTHI/MTLO source).
- `B`  in  WIDTH  operand 2 (divisor).
- `busy`  out  1  multi-cycle operation in flight.
- `HI`  out  WIDTH  HI register (product upper half / remainder).
- `LO`  out  WIDTH  LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN.
  - IDLE + `start` + MULT/MULTU/DIV/DIVU: go to RUN.
    - Latch the op and compute the result into internal pending registers.
    - Load the counter with MUL_LAT or DIV_LAT.
  - IDLE + `start` + MTHI: HI ← A at that edge. MTLO: LO ← A at that edge. State stays IDLE.
  - IDLE + `start` + NOP/111: no effect.
  - RUN: the counter decrements each cycle. At the edge where it reaches 0:
    - HI/LO ← pending values;
    - go to IDLE.
  - `start` while in RUN is ignored entirely, including MTHI/MTLO. Operands are never re-sampled.
- MULT: signed WIDTH×WIDTH → 2·WIDTH product; HI = upper WIDTH bits, LO = lower.
- MULTU: unsigned, same split.
- DIV: signed, truncates toward zero; LO = quotient, HI = remainder, with the remainder taking the dividend's sign.
  - Overflow case, A = most-negative and B = −1: LO = A, HI = 0.
- DIVU: unsigned; LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO = all ones, HI = A. Takes the full DIV_LAT latency.
- HI/LO change only on a commit or an MTHI/MTLO. They are never partially updated.

## Timing
- Reset values: `busy`=0, `HI`=0, `LO`=0, state IDLE, counter 0.
- `reset` during RUN aborts the operation: pending result discarded, HI/LO forced to 0.
- `busy` is registered:
  - It rises the cycle after the accepting edge.
  - It stays high exactly LAT cycles.
  - It falls in the same cycle HI/LO show the new values.
- Latency: start accepted at edge E → new HI/LO visible after edge E+LAT.
- MTHI/MTLO: result visible after the accepting edge (1 cycle); `busy` stays 0.
- Back-to-back operations: a `start` in the first cycle where `busy`=0 is accepted. There are no dead cycles between operations.
- HI/LO stay stable throughout RUN; reads during RUN return the old values.

## Test plan
All cases use WIDTH=32, MUL_LAT=5, DIV_LAT=10.
- Reset and MTHI/MTLO:
  - Assert `reset` → HI=LO=0, busy=0.
  - MTHI A=0x12345678 → HI=0x12345678 after 1 edge, busy never rises.
- Multiply:
  - MULT A=0xFFFFFFFE, B=3 → busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- Divide:
  - DIV A=0xFFFFFFF9, B=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2 → LO=3, HI=1.
  - DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: DIVU A=0x55, B=0 → after 10 cycles LO=0xFFFFFFFF, HI=0x55.
- Start while busy:
  - MULT 3×4 begins.
  - At cycle 2, `start` with MTLO A=0xAA and at cycle 3 with DIV → both ignored.
  - Final HI=0, LO=12; busy is 5 cycles total.
- Reset mid-operation:
  - DIV 100/7 started, `reset` pulsed at cycle 4 → busy=0, HI=LO=0 immediately.
  - No later commit of 14/2.
  - A following MULT 2×2 → LO=4 after 5 cycles.
